// File: rtl/mem_perf_pkg.sv
// Shared types and constants for the DRAM read performance monitor.
package mem_perf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } mon_state_t;

    localparam int          DATA_W_DFLT = 512;
    localparam int          LANES       = DATA_W_DFLT / 32;
    localparam logic [15:0] LAT_SAT     = 16'hFFFF;

endpackage

// File: rtl/mem_rd_pattern_chk.sv
// Registered fill-pattern checker: lane j of beat n must equal seed + n*lanes + j.
// Instantiated by mem_rd_perf_mon only when MEM_RD_PERF_CHECK_EN is defined.
module mem_rd_pattern_chk
    import mem_perf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p0,
    input  logic [CNT_W-1:0]  beat_idx,
    input  logic [31:0]       seed,
    input  logic [DATA_W-1:0] rdata,
    output logic              err_p1
);

    localparam int NL = DATA_W / 32;

    logic [31:0]   base;
    logic [NL-1:0] lane_bad;

    always_comb begin
        base     = seed + 32'(beat_idx) * 32'(NL);
        lane_bad = '0;
        for (int j = 0; j < NL; j++) begin
            lane_bad[j] = rdata[j*32 +: 32] != (base + 32'(j));
        end
    end

    // p0 -> p1: one flag per beat, counted by the top a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= vld_p0 & (|lane_bad);
        end
    end

endmodule

// File: rtl/mem_rd_perf_mon.sv
// Passive AXI read-side monitor: beats, bursts, run cycles, AR->R latency, RRESP errors.
// Define MEM_RD_PERF_CHECK_EN to build the read-data pattern checker.
module mem_rd_perf_mon
    import mem_perf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = 32,
    parameter int LAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  expected_beats,
    input  logic [31:0]       seed,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [7:0]        arlen,
    input  logic              rvalid,
    input  logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              done,
    output logic [63:0]       cycle_count,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  burst_count,
    output logic [CNT_W-1:0]  resp_err_count,
    output logic [CNT_W-1:0]  data_err_count,
    output logic [LAT_W-1:0]  lat_max,
    output logic [LAT_W-1:0]  lat_min,
    output logic              overrun
);

    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    mon_state_t       state_q, state_d;
    logic             enable_q;
    logic [CNT_W-1:0] exp_q;
    logic [LAT_W-1:0] lat_timer;
    logic             lat_open;

    logic beat_hs, ar_hs, active, cnt_beat, cnt_ar, arm_clr, last_beat;

    // arlen/rlast are snooped but the run end is defined by expected_beats
    logic unused_snoop;
    assign unused_snoop = ^{arlen, rlast};

    assign beat_hs   = rvalid & rready;
    assign ar_hs     = arvalid & arready;
    assign active    = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign cnt_beat  = beat_hs & active;
    assign cnt_ar    = ar_hs & active;
    assign arm_clr   = (state_q == ST_IDLE) && enable && !enable_q;
    assign last_beat = cnt_beat && ((beat_count + CNT_W'(1)) == exp_q);
    assign done      = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm_clr) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!enable)                  state_d = ST_IDLE;
                else if (exp_q == '0)         state_d = ST_DRAIN;
                else if (last_beat)           state_d = ST_DRAIN;
                else if (ar_hs)               state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)                  state_d = ST_IDLE;
                else if (last_beat)           state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = enable ? ST_DONE : ST_IDLE;
            ST_DONE:  if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Run configuration is plain data, captured only on arming
    always_ff @(posedge clk) begin
        if (arm_clr) begin
            exp_q <= expected_beats;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count    <= '0;
            beat_count     <= '0;
            burst_count    <= '0;
            resp_err_count <= '0;
            lat_max        <= '0;
            lat_min        <= '1;
            lat_timer      <= '0;
            lat_open       <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (beat_hs && !active) overrun <= 1'b1;
            if (arm_clr) begin
                cycle_count    <= '0;
                beat_count     <= '0;
                burst_count    <= '0;
                resp_err_count <= '0;
                lat_max        <= '0;
                lat_min        <= '1;
                lat_timer      <= '0;
                lat_open       <= 1'b0;
            end else begin
                if (cnt_ar) burst_count <= burst_count + CNT_W'(1);
                if (cnt_beat) begin
                    beat_count <= beat_count + CNT_W'(1);
                    if (rresp != 2'b00) resp_err_count <= resp_err_count + CNT_W'(1);
                end
                if (cnt_ar && state_q == ST_ARMED) cycle_count <= 64'd1;
                else if (state_q == ST_RUN)         cycle_count <= sat_inc64(cycle_count);
                // A beat closes the open burst before a same-cycle AR reopens it
                if (cnt_beat && lat_open) begin
                    if (lat_timer > lat_max) lat_max <= lat_timer;
                    if (lat_timer < lat_min) lat_min <= lat_timer;
                end
                if (cnt_ar) begin
                    lat_open  <= 1'b1;
                    lat_timer <= LAT_W'(1);
                end else if (cnt_beat) begin
                    lat_open  <= 1'b0;
                end else if (lat_open) begin
                    lat_timer <= sat_inc_lat(lat_timer);
                end
            end
        end
    end

`ifdef MEM_RD_PERF_CHECK_EN
    logic [31:0] seed_q;
    logic        err_p1;

    always_ff @(posedge clk) begin
        if (arm_clr) begin
            seed_q <= seed;
        end
    end

    mem_rd_pattern_chk #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_pattern_chk (
        .clk      (clk),
        .rst      (rst),
        .vld_p0   (cnt_beat),
        .beat_idx (beat_count),
        .seed     (seed_q),
        .rdata    (rdata),
        .err_p1   (err_p1)
    );

    always_ff @(posedge clk) begin
        if (rst || arm_clr) begin
            data_err_count <= '0;
        end else if (err_p1) begin
            data_err_count <= data_err_count + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg     = ^{seed, rdata};
    assign data_err_count = '0;
`endif

endmodule

// File: tb/tb_mem_rd_perf_mon.sv
// Directed bench for mem_rd_perf_mon with hand-computed expectations.
module tb_mem_rd_perf_mon;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [31:0]  expected_beats;
    logic [31:0]  seed;
    logic         arvalid, arready;
    logic [7:0]   arlen;
    logic         rvalid, rready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         done;
    logic [63:0]  cycle_count;
    logic [31:0]  beat_count, burst_count, resp_err_count, data_err_count;
    logic [15:0]  lat_max, lat_min;
    logic         overrun;

    int n_chk = 0;
    int n_err = 0;

`ifdef MEM_RD_PERF_CHECK_EN
    localparam int CORRUPT_ERRS = 1;
`else
    localparam int CORRUPT_ERRS = 0;
`endif

    always #5 clk = ~clk;

    mem_rd_perf_mon dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .expected_beats (expected_beats),
        .seed           (seed),
        .arvalid        (arvalid),
        .arready        (arready),
        .arlen          (arlen),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .done           (done),
        .cycle_count    (cycle_count),
        .beat_count     (beat_count),
        .burst_count    (burst_count),
        .resp_err_count (resp_err_count),
        .data_err_count (data_err_count),
        .lat_max        (lat_max),
        .lat_min        (lat_min),
        .overrun        (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pat(input int n, input logic [31:0] sd);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = sd + 32'(n) * 32'd16 + 32'(j);
        return d;
    endfunction

    task automatic arm(input logic [31:0] nb, input logic [31:0] sd);
        enable = 1'b0;
        tick();
        expected_beats = nb;
        seed           = sd;
        enable         = 1'b1;
        tick();
    endtask

    task automatic run_burst(input int nbeats, input int first, input int gap,
                             input logic [31:0] sd, input int bad, input int ea, input int eb);
        arvalid = 1'b1;
        arlen   = 8'(nbeats - 1);
        tick();
        arvalid = 1'b0;
        repeat (gap - 1) tick();
        for (int k = 0; k < nbeats; k++) begin
            int n = first + k;
            rdata = pat(n, sd);
            if (n == bad) rdata[3*32 +: 32] = ~rdata[3*32 +: 32];
            rresp  = (n == ea || n == eb) ? 2'b10 : 2'b00;
            rlast  = (k == nbeats - 1);
            rvalid = 1'b1;
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done"},   64'(done), 64'd0);
        chk({tag, "_cycles"}, cycle_count, 64'd0);
        chk({tag, "_beats"},  64'(beat_count), 64'd0);
        chk({tag, "_bursts"}, 64'(burst_count), 64'd0);
        chk({tag, "_resp"},   64'(resp_err_count), 64'd0);
        chk({tag, "_derr"},   64'(data_err_count), 64'd0);
        chk({tag, "_latmax"}, 64'(lat_max), 64'd0);
        chk({tag, "_latmin"}, 64'(lat_min), 64'hFFFF);
        chk({tag, "_ovr"},    64'(overrun), 64'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; expected_beats = '0; seed = '0;
        arvalid = 1'b0; arready = 1'b1; arlen = '0;
        rvalid = 1'b0; rready = 1'b1; rdata = '0; rresp = '0; rlast = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // 256 clean beats, one burst, no stalls
        arm(32'd256, 32'd0);
        run_burst(256, 0, 1, 32'd0, -1, -1, -1);
        chk("t1_done_early", 64'(done), 64'd0);
        tick();
        chk("t1_done",   64'(done), 64'd1);
        chk("t1_beats",  64'(beat_count), 64'd256);
        chk("t1_bursts", 64'(burst_count), 64'd1);
        chk("t1_resp",   64'(resp_err_count), 64'd0);
        chk("t1_derr",   64'(data_err_count), 64'd0);
        chk("t1_cycles", cycle_count, 64'd257);
        chk("t1_latmin", 64'(lat_min), 64'd1);
        chk("t1_latmax", 64'(lat_max), 64'd1);

        // lane 3 of beat 10 corrupted
        arm(32'd256, 32'd0);
        run_burst(256, 0, 1, 32'd0, 10, -1, -1);
        tick();
        chk("t2_done",  64'(done), 64'd1);
        chk("t2_derr",  64'(data_err_count), 64'(CORRUPT_ERRS));
        chk("t2_beats", 64'(beat_count), 64'd256);

        // two bursts, first R 7 then 12 cycles after AR
        arm(32'd8, 32'h1234_0000);
        run_burst(4, 0, 7, 32'h1234_0000, -1, -1, -1);
        run_burst(4, 4, 12, 32'h1234_0000, -1, -1, -1);
        tick();
        chk("t3_done",   64'(done), 64'd1);
        chk("t3_latmin", 64'(lat_min), 64'd7);
        chk("t3_latmax", 64'(lat_max), 64'd12);
        chk("t3_bursts", 64'(burst_count), 64'd2);
        chk("t3_beats",  64'(beat_count), 64'd8);
        chk("t3_cycles", cycle_count, 64'd27);
        chk("t3_derr",   64'(data_err_count), 64'd0);

        // zero-beat run completes on its own
        arm(32'd0, 32'd0);
        chk("t5_done_armed", 64'(done), 64'd0);
        tick();
        chk("t5_done_drain", 64'(done), 64'd0);
        tick();
        chk("t5_done",   64'(done), 64'd1);
        chk("t5_beats",  64'(beat_count), 64'd0);
        chk("t5_bursts", 64'(burst_count), 64'd0);
        chk("t5_cycles", cycle_count, 64'd0);
        chk("t5_latmin", 64'(lat_min), 64'hFFFF);

        // rresp errors on beats 0 and 5, then a stray beat in DONE
        arm(32'd8, 32'hA5A5_0000);
        run_burst(8, 0, 1, 32'hA5A5_0000, -1, 0, 5);
        tick();
        chk("t4_done",  64'(done), 64'd1);
        chk("t4_resp",  64'(resp_err_count), 64'd2);
        chk("t4_beats", 64'(beat_count), 64'd8);
        chk("t4_derr",  64'(data_err_count), 64'd0);
        chk("t4_ovr_pre", 64'(overrun), 64'd0);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("t4_ovr",        64'(overrun), 64'd1);
        chk("t4_beats_hold", 64'(beat_count), 64'd8);

        // reset at beat 100 of a 256-beat run, then a fresh 64-beat run
        arm(32'd256, 32'h0000_0100);
        arvalid = 1'b1;
        arlen   = 8'd255;
        tick();
        arvalid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            rdata  = pat(n, 32'h0000_0100);
            rvalid = 1'b1;
            tick();
        end
        chk("t6_beats_mid", 64'(beat_count), 64'd100);
        rdata  = pat(100, 32'h0000_0100);
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst    = 1'b0;
        rvalid = 1'b0;
        chk_reset_vals("t6_rst");
        tick();
        chk("t6_derr_quiet", 64'(data_err_count), 64'd0);
        arm(32'd64, 32'h0BAD_0000);
        run_burst(64, 0, 3, 32'h0BAD_0000, -1, -1, -1);
        tick();
        chk("t6_done",   64'(done), 64'd1);
        chk("t6_beats",  64'(beat_count), 64'd64);
        chk("t6_bursts", 64'(burst_count), 64'd1);
        chk("t6_lat",    64'(lat_max), 64'd3);
        chk("t6_cycles", cycle_count, 64'd67);
        chk("t6_derr",   64'(data_err_count), 64'd0);

        // results hold once enable drops
        enable = 1'b0;
        tick();
        tick();
        chk("hold_done",  64'(done), 64'd0);
        chk("hold_beats", 64'(beat_count), 64'd64);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
